// File: rtl/sw_job_sequencer_if.sv
// Bundle between the job sequencer, its T/S memories, the job requester and the systolic array.
// The sequencer takes the master side; o_timeout exists only with SW_JOB_SEQUENCER_WATCHDOG_EN.
interface sw_job_sequencer_if #(
  parameter int PE_SIZE     = 16,
  parameter int PE_SIZE_LOG = 4,
  parameter int VEF_BIT     = 16,
  parameter int T_DEPTH_LOG = 10
);
  logic                   i_job_start;
  logic [15:0]            i_s_len;
  logic [23:0]            i_param;
  logic [T_DEPTH_LOG-1:0] o_t_addr;
  logic [17:0]            i_t_data;
  logic [15:0]            o_s_addr;
  logic [2*PE_SIZE-1:0]   i_s_data;
  logic                   o_set_t;
  logic [17:0]            o_t;
  logic                   i_busy;
  logic                   o_param_valid;
  logic [23:0]            o_param;
  logic                   o_start_cal;
  logic                   i_request_s;
  logic [2*PE_SIZE-1:0]   o_s;
  logic [PE_SIZE_LOG:0]   o_s_valid;
  logic [VEF_BIT-1:0]     i_result;
  logic                   i_valid;
  logic [VEF_BIT-1:0]     o_score;
  logic                   o_done;
  logic                   o_idle;
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
  logic                   o_timeout;
`endif

  modport master (
    input  i_job_start, i_s_len, i_param, i_t_data, i_s_data, i_busy,
           i_request_s, i_result, i_valid,
    output o_t_addr, o_s_addr, o_set_t, o_t, o_param_valid, o_param,
           o_start_cal, o_s, o_s_valid, o_score, o_done, o_idle
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
    , output o_timeout
`endif
  );

  modport slave (
    output i_job_start, i_s_len, i_param, i_t_data, i_s_data, i_busy,
           i_request_s, i_result, i_valid,
    input  o_t_addr, o_s_addr, o_set_t, o_t, o_param_valid, o_param,
           o_start_cal, o_s, o_s_valid, o_score, o_done, o_idle
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
    , input o_timeout
`endif
  );
endinterface

// File: rtl/sw_job_sequencer.sv
// Sequences one Smith-Waterman job: T load, param/start strobes, S streaming on array request (1-cycle
// memory latency), score capture. Waits on i_busy/i_valid; watchdog via SW_JOB_SEQUENCER_WATCHDOG_EN.
module sw_job_sequencer #(
  parameter int PE_SIZE     = 16,
  parameter int PE_SIZE_LOG = 4,
  parameter int VEF_BIT     = 16,
  parameter int T_DEPTH_LOG = 10
) (
  input logic                clk,
  input logic                rst_n,
  sw_job_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD_T, WAIT_BUSY, SET_PARAM, START, STREAM_S, WAIT_RES, DONE
  } state_t;
  typedef logic [PE_SIZE_LOG:0] svld_t;

  state_t                 state_q;
  logic [15:0]            remaining_q;
  logic [23:0]            param_q;
  logic [T_DEPTH_LOG-1:0] t_addr_q;
  logic [T_DEPTH_LOG-1:0] t_idx_q;
  logic                   first_q;
  logic                   set_t_q;
  logic [17:0]            t_q;
  logic                   param_vld_q;
  logic                   start_q;
  logic                   done_q;
  logic [15:0]            s_addr_q;
  svld_t                  s_valid_q;
  logic [VEF_BIT-1:0]     score_q;
  svld_t                  s_take_d;
  logic                   t_last_d;
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
  logic                   timeout_q;
  logic [15:0]            wd_q;
  logic                   wd_expire_d;

  assign wd_expire_d = (wd_q == 16'hFFFF);
`endif

  // i_t_data always belongs to the word indexed by t_idx_q (address runs one ahead)
  assign t_last_d = (bus.i_t_data[16:14] != 3'b000) || (t_idx_q == '1);
  assign s_take_d = (remaining_q >= 16'(PE_SIZE)) ? svld_t'(PE_SIZE)
                                                   : remaining_q[PE_SIZE_LOG:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      param_q     <= '0;
      t_addr_q    <= '0;
      t_idx_q     <= '0;
      first_q     <= 1'b0;
      set_t_q     <= 1'b0;
      t_q         <= '0;
      param_vld_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      s_addr_q    <= '0;
      s_valid_q   <= '0;
      score_q     <= '0;
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
      timeout_q   <= 1'b0;
      wd_q        <= '0;
`endif
    end else begin
      set_t_q     <= 1'b0;
      t_q         <= '0;
      param_vld_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      s_valid_q   <= '0;
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
      timeout_q   <= 1'b0;
      wd_q        <= '0;
`endif
      case (state_q)
        IDLE: begin
          // word 0 was read on this edge since the address idles at 0
          if (bus.i_job_start) begin
            remaining_q <= bus.i_s_len;
            param_q     <= bus.i_param;
            t_addr_q    <= T_DEPTH_LOG'(1);
            t_idx_q     <= '0;
            first_q     <= 1'b1;
            s_addr_q    <= '0;
            state_q     <= LOAD_T;
          end
        end
        LOAD_T: begin
          t_q      <= bus.i_t_data;
          set_t_q  <= first_q;
          first_q  <= 1'b0;
          t_addr_q <= t_addr_q + 1'b1;
          t_idx_q  <= t_idx_q + 1'b1;
          if (t_last_d) begin
            t_addr_q <= '0;
            state_q  <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!bus.i_busy) begin
            param_vld_q <= 1'b1;
            state_q     <= SET_PARAM;
          end
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
          else if (wd_expire_d) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
`endif
        end
        SET_PARAM: begin
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          state_q <= (remaining_q == 16'd0) ? WAIT_RES : STREAM_S;
        end
        STREAM_S: begin
          // a score ends the job at once; unsent S words are dropped
          if (bus.i_valid) begin
            score_q <= bus.i_result;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (bus.i_request_s && remaining_q != 16'd0) begin
            s_valid_q   <= s_take_d;
            remaining_q <= remaining_q - 16'(s_take_d);
            s_addr_q    <= s_addr_q + 16'd1;
            if (remaining_q == 16'(s_take_d)) begin
              state_q <= WAIT_RES;
            end
          end
        end
        WAIT_RES: begin
          if (bus.i_valid) begin
            score_q <= bus.i_result;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
          else if (wd_expire_d) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_t_addr      = t_addr_q;
  assign bus.o_s_addr      = s_addr_q;
  assign bus.o_set_t       = set_t_q;
  assign bus.o_t           = t_q;
  assign bus.o_param_valid = param_vld_q;
  assign bus.o_param       = param_q;
  assign bus.o_start_cal   = start_q;
  // S data arrives from memory in the strobe cycle, so it is gated rather than registered
  assign bus.o_s           = (s_valid_q != '0) ? bus.i_s_data : '0;
  assign bus.o_s_valid     = s_valid_q;
  assign bus.o_score       = score_q;
  assign bus.o_done        = done_q;
  assign bus.o_idle        = (state_q == IDLE);
`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
  assign bus.o_timeout     = timeout_q;
`endif
endmodule

// File: tb/tb_sw_job_sequencer.sv
// Bench for sw_job_sequencer: table of jobs plus reset/watchdog sequences; S words checked by scoreboard.
module tb_sw_job_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   popped = 0;
  bit   sb_en = 1'b0;

  sw_job_sequencer_if #(.PE_SIZE(16), .PE_SIZE_LOG(4), .VEF_BIT(16), .T_DEPTH_LOG(10)) bus ();

  sw_job_sequencer #(.PE_SIZE(16), .PE_SIZE_LOG(4), .VEF_BIT(16), .T_DEPTH_LOG(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [17:0] tmem [1024];
  logic [31:0] smem [256];
  always @(posedge clk) begin
    bus.i_t_data <= tmem[bus.o_t_addr];
    bus.i_s_data <= smem[bus.o_s_addr[7:0]];
  end

  typedef struct {
    int          s_len;
    int          t_len;
    logic [2:0]  t_mark;
    int          busy_cyc;
    int          abort_after;
    bit          gap;
    bit          restart;
    logic [23:0] param;
    logic [15:0] result;
    int          exp_words;
  } vec_t;

  typedef struct {
    int          vld;
    logic [31:0] dat;
    int          cyc;
  } sexp_t;

  sexp_t sq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // every S strobe must match the oldest outstanding request, one cycle after it
  always @(negedge clk) begin
    if (sb_en && bus.o_s_valid != 0) begin
      if (sq.size() == 0) begin
        check("s_unexpected", 64'(bus.o_s_valid), 64'd0);
      end else begin
        sexp_t e;
        e = sq.pop_front();
        check("s_valid", 64'(bus.o_s_valid), 64'(e.vld));
        check("s_data", 64'(bus.o_s), 64'(e.dat));
        check("s_latency", 64'(cyc), 64'(e.cyc));
        popped++;
      end
    end
  end

  task automatic clear_inputs();
    bus.i_job_start = 1'b0;
    bus.i_s_len     = '0;
    bus.i_param     = '0;
    bus.i_busy      = 1'b0;
    bus.i_request_s = 1'b0;
    bus.i_result    = '0;
    bus.i_valid     = 1'b0;
  endtask

  task automatic recover();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sq.delete();
    @(negedge clk);
  endtask

  function automatic vec_t mk(int s_len, int t_len, logic [2:0] t_mark, int busy_cyc, int abort_after,
                              bit gap, bit restart, logic [23:0] param, logic [15:0] result, int exp_words);
    vec_t v;
    v.s_len = s_len; v.t_len = t_len; v.t_mark = t_mark; v.busy_cyc = busy_cyc;
    v.abort_after = abort_after; v.gap = gap; v.restart = restart; v.param = param;
    v.result = result; v.exp_words = exp_words;
    return v;
  endfunction

  task automatic fill_t(input int t_len, input logic [2:0] t_mark);
    for (int i = 0; i < 1024; i++) tmem[i] = {1'b1, 3'b000, 14'(i * 3 + 5)};
    if (t_mark != 3'b000) tmem[t_len-1][16:14] = t_mark;
  endtask

  task automatic run_job(input vec_t v);
    int    rem;
    int    issued;
    int    k;
    sexp_t e;
    fill_t(v.t_len, v.t_mark);
    popped = 0;
    sq.delete();
    bus.i_s_len = 16'(v.s_len);
    bus.i_param = v.param;
    bus.i_busy = 1'b1;
    bus.i_job_start = 1'b1;
    @(negedge clk);
    bus.i_job_start = 1'b0;
    check("idle_drop", 64'(bus.o_idle), 64'd0);
    if (v.restart) begin
      bus.i_job_start = 1'b1;
      bus.i_s_len = 16'd7;
      bus.i_param = ~v.param;
    end
    @(negedge clk);
    bus.i_job_start = 1'b0;
    bus.i_s_len = 16'(v.s_len);
    bus.i_param = v.param;
    k = 0;
    while (!bus.o_set_t && k < 8) begin @(negedge clk); k++; end
    check("set_t_seen", 64'(bus.o_set_t), 64'd1);
    if (!bus.o_set_t) begin recover(); return; end
    for (int i = 0; i < v.t_len; i++) begin
      check("t_word", 64'(bus.o_t), 64'(tmem[i]));
      check("set_t_first", 64'(bus.o_set_t), 64'(i == 0));
      @(negedge clk);
    end
    check("t_quiet", 64'(bus.o_t), 64'd0);
    check("set_t_quiet", 64'(bus.o_set_t), 64'd0);
    repeat (v.busy_cyc) begin
      check("param_while_busy", 64'(bus.o_param_valid), 64'd0);
      @(negedge clk);
    end
    bus.i_busy = 1'b0;
    k = 0;
    while (!bus.o_param_valid && k < 8) begin @(negedge clk); k++; end
    check("param_valid", 64'(bus.o_param_valid), 64'd1);
    if (!bus.o_param_valid) begin recover(); return; end
    check("busy_to_param", 64'(k), 64'd1);
    check("param", 64'(bus.o_param), 64'(v.param));
    @(negedge clk);
    check("param_pulse", 64'(bus.o_param_valid), 64'd0);
    check("start_cal", 64'(bus.o_start_cal), 64'd1);
    @(negedge clk);
    check("start_pulse", 64'(bus.o_start_cal), 64'd0);
    rem = v.s_len;
    issued = 0;
    k = 0;
    while (rem > 0 && issued != v.abort_after) begin
      if (v.gap && k[0]) begin
        bus.i_request_s = 1'b0;
      end else begin
        bus.i_request_s = 1'b1;
        e.vld = (rem > 16) ? 16 : rem;
        e.dat = smem[issued];
        e.cyc = cyc + 1;
        sq.push_back(e);
        rem -= e.vld;
        issued++;
      end
      k++;
      @(negedge clk);
    end
    if (issued != v.abort_after) begin
      // requests once the S budget is spent must be ignored
      bus.i_request_s = 1'b1;
      repeat (2) @(negedge clk);
    end
    bus.i_request_s = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_result = v.result;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("done", 64'(bus.o_done), 64'd1);
    check("score", 64'(bus.o_score), 64'(v.result));
    bus.i_request_s = 1'b1;
    @(negedge clk);
    check("done_pulse", 64'(bus.o_done), 64'd0);
    check("idle_back", 64'(bus.o_idle), 64'd1);
    check("score_hold", 64'(bus.o_score), 64'(v.result));
    @(negedge clk);
    bus.i_request_s = 1'b0;
    check("s_words", 64'(popped), 64'(v.exp_words));
    check("sq_empty", 64'(sq.size()), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int k;
    vecs[0] = mk(40,   3,    3'b001, 0, -1, 1'b0, 1'b0, 24'h21_FEFD, 16'd100,   3);
    vecs[1] = mk(0,    2,    3'b100, 3, -1, 1'b0, 1'b0, 24'h53_F0E1, 16'd37,    0);
    vecs[2] = mk(40,   3,    3'b001, 1,  1, 1'b0, 1'b0, 24'h12_8040, 16'd12,    1);
    vecs[3] = mk(33,   5,    3'b010, 2, -1, 1'b1, 1'b1, 24'hA5_5A3C, 16'd500,   3);
    vecs[4] = mk(16,   1,    3'b111, 0, -1, 1'b0, 1'b0, 24'h7F_0102, 16'hBEEF,  1);
    vecs[5] = mk(5,    1024, 3'b000, 0, -1, 1'b0, 1'b0, 24'h36_2211, 16'd7,     1);

    for (int i = 0; i < 256; i++) smem[i] = $urandom;
    fill_t(1, 3'b001);
    clear_inputs();
    #3;
    check("rst_idle", 64'(bus.o_idle), 64'd1);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_s_valid", 64'(bus.o_s_valid), 64'd0);
    check("rst_t_addr", 64'(bus.o_t_addr), 64'd0);
    check("rst_score", 64'(bus.o_score), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // reset in the middle of S streaming
    sb_en = 1'b0;
    fill_t(2, 3'b001);
    bus.i_s_len = 16'd100;
    bus.i_param = 24'h11_2233;
    bus.i_job_start = 1'b1;
    @(negedge clk);
    bus.i_job_start = 1'b0;
    k = 0;
    while (!bus.o_start_cal && k < 30) begin @(negedge clk); k++; end
    check("mid_start_seen", 64'(bus.o_start_cal), 64'd1);
    @(negedge clk);
    bus.i_request_s = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_s_valid", 64'(bus.o_s_valid), 64'd16);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_s_valid", 64'(bus.o_s_valid), 64'd0);
    check("mid_rst_s", 64'(bus.o_s), 64'd0);
    check("mid_rst_idle", 64'(bus.o_idle), 64'd1);
    check("mid_rst_score", 64'(bus.o_score), 64'd0);
    check("mid_rst_s_addr", 64'(bus.o_s_addr), 64'd0);
    check("mid_rst_param", 64'(bus.o_param), 64'd0);
    bus.i_request_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_auto_start", 64'(bus.o_idle), 64'd1);
    end
    sb_en = 1'b1;
    run_job(vecs[0]);

`ifdef SW_JOB_SEQUENCER_WATCHDOG_EN
    begin
      int dones;
      int w_cyc;
      fill_t(1, 3'b001);
      bus.i_s_len = 16'd8;
      bus.i_busy = 1'b1;
      bus.i_job_start = 1'b1;
      @(negedge clk);
      bus.i_job_start = 1'b0;
      k = 0;
      while (!bus.o_set_t && k < 8) begin @(negedge clk); k++; end
      w_cyc = cyc;
      dones = 0;
      k = 0;
      while (!bus.o_timeout && k < 70000) begin
        @(negedge clk);
        if (bus.o_done) dones++;
        k++;
      end
      check("wd_timeout", 64'(bus.o_timeout), 64'd1);
      check("wd_delay", 64'(cyc - w_cyc), 64'd65536);
      check("wd_no_done", 64'(dones), 64'd0);
      @(negedge clk);
      check("wd_pulse", 64'(bus.o_timeout), 64'd0);
      check("wd_idle", 64'(bus.o_idle), 64'd1);
      bus.i_busy = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sw_job_sequencer.md
SW_JOB_SEQUENCER -- requirements
Module: sw_job_sequencer

Interface
REQ-001 SHALL have parameter PE_SIZE, default 16, symbols per S word (2 bits each).
REQ-002 SHALL have parameter PE_SIZE_LOG, default 4, log2(PE_SIZE).
REQ-003 SHALL have parameter VEF_BIT, default 16, score width.
REQ-004 SHALL have parameter T_DEPTH_LOG, default 10, T-memory address width.
REQ-005 SHALL have ports, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_job_start  in  1  job request pulse.
- i_s_len  in  16  S length in symbols.
- i_param  in  24  {match[23:20], mismatch[19:16], minusAlpha[15:8], minusBeta[7:0]}.
- o_t_addr  out  T_DEPTH_LOG  T-memory read address; data returns next cycle.
- i_t_data  in  18  T word; bits[16:14]!=0 marks last word.
- o_s_addr  out  16  S-memory word address; data returns next cycle.
- i_s_data  in  2*PE_SIZE  S word.
- o_set_t, o_t[17:0]  out  T load strobe and word to the array top.
- i_busy  in  1  array busy.
- o_param_valid  out  1  parameter strobe; o_param[23:0] out, held.
- o_start_cal  out  1  calculation start pulse.
- i_request_s  in  1  array requests next S word.
- o_s  out  2*PE_SIZE  S word to array.
- o_s_valid  out  PE_SIZE_LOG+1  symbols valid in o_s.
- i_result  in  VEF_BIT  array score; i_valid  in  1  score strobe.
- o_score  out  VEF_BIT  captured score; o_done  out  1  job-complete pulse; o_idle  out  1  sequencer in IDLE.

Function
REQ-006 SHALL implement states IDLE, LOAD_T, WAIT_BUSY, SET_PARAM, START, STREAM_S, WAIT_RES, DONE.
REQ-007 IDLE: o_idle=1; i_job_start latches i_s_len and i_param, issues o_t_addr=0, and moves to LOAD_T; i_job_start in any other state SHALL be ignored.
REQ-008 LOAD_T: each cycle drives o_t=i_t_data and increments the address; o_set_t=1 on the first word only; after the word with bits[16:14]!=0, or after address 2^T_DEPTH_LOG-1 (forced end), moves to WAIT_BUSY.
REQ-009 WAIT_BUSY: moves to SET_PARAM on the first cycle with i_busy=0.
REQ-010 SET_PARAM: o_param_valid=1 for exactly one cycle, then START; START: o_start_cal=1 for exactly one cycle, then STREAM_S, or WAIT_RES if s_len=0.
REQ-011 STREAM_S: i_request_s=1 at cycle n with remaining>0 SHALL issue the next o_s_addr at cycle n and drive o_s=i_s_data and o_s_valid=min(PE_SIZE, remaining) at n+1, each for one cycle; back-to-back requests are served every cycle.
REQ-012 remaining SHALL decrement by the symbols sent; a request with remaining=0 SHALL be ignored (o_s_valid=0); when remaining reaches 0, moves to WAIT_RES.
REQ-013 i_valid in STREAM_S or WAIT_RES SHALL capture i_result into o_score and move to DONE; remaining S words are abandoned; i_valid in other states SHALL be ignored.
REQ-014 DONE: o_done=1 for one cycle, then IDLE; o_score SHALL hold until the next capture.
REQ-015 When no word or strobe is driven, o_s, o_s_valid, o_t, o_set_t, o_param_valid, and o_start_cal SHALL be 0.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE, zero all outputs and counters (o_idle=1), and abort any job in progress.
REQ-017 The first job after reset deassertion SHALL require a new i_job_start.

Configuration
REQ-018 With macro SW_JOB_SEQUENCER_WATCHDOG_EN defined: a 16-bit counter SHALL count cycles in WAIT_BUSY and WAIT_RES; at 65535 it SHALL assert output o_timeout for one cycle, skip o_done, and return to IDLE; the counter clears on each state entry.
REQ-019 Without SW_JOB_SEQUENCER_WATCHDOG_EN: no counter and no o_timeout port; the wait states wait indefinitely.

Verification
REQ-020 T of 3 words (third has bits[16:14]=3'b001) -> o_set_t is 1 on word 0 only; 3 consecutive o_t words; then WAIT_BUSY.
REQ-021 PE_SIZE=16, s_len=40, i_request_s held high -> o_s_valid 16, 16, 8 on consecutive cycles, then WAIT_RES.
REQ-022 s_len=0 -> o_start_cal is followed directly by WAIT_RES with no o_s_valid; i_valid with i_result=37 -> o_score=37 and o_done pulses one cycle later.
REQ-023 i_valid with i_result=12 after the first of 3 S words -> o_score=12 and o_done; no further o_s_valid.
REQ-024 rst_n low mid-STREAM_S -> all outputs 0 and o_idle=1 in the same cycle; i_job_start in LOAD_T is ignored.
REQ-025 With watchdog enabled, i_busy stuck high -> o_timeout pulses after 65535 cycles, with no o_done.
